router_pkt_reg: RTL

Parametrised packet datapath register for the 1x3 router. It sits between the input port and the destination FIFOs, under control of the router FSM. It latches the header and forwards header and payload to the FIFO write bus. It buffers bytes in a configurable skid buffer while the selected FIFO is full, accumulates a running check over the packet, and compares it with the trailing check byte. It also keeps a saturating error count.

---
 rtl/router_pkt_reg.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/router_pkt_reg.sv
// Router packet datapath register: header latch, FIFO write bus, skid buffer while FIFO full, running check (ROUTER_PKT_REG_CRC8_EN selects CRC-8 over XOR).
// One cycle latency to dout; backpressure via fifo_full absorbs up to SKID_DEPTH bytes, extra bytes are dropped and flagged.
module router_pkt_reg #(
    parameter int DATA_W     = 8,
    parameter int SKID_DEPTH = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                          router_clock,
    input  logic                          resetn,
    input  logic                          pkt_valid,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          fifo_full,
    input  logic                          rst_int_reg,
    input  logic                          detect_add,
    input  logic                          lfd_state,
    input  logic                          ld_state,
    input  logic                          laf_state,
    input  logic                          full_state,
    output logic [DATA_W-1:0]             dout,
    output logic                          dout_valid,
    output logic                          parity_done,
    output logic                          low_pkt_valid,
    output logic                          err,
    output logic [ERR_CNT_W-1:0]          err_count,
    output logic [$clog2(SKID_DEPTH):0]   skid_level,
    output logic                          skid_overflow
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int LVL_W = $clog2(SKID_DEPTH) + 1;

`ifdef ROUTER_PKT_REG_CRC8_EN
    if (DATA_W != 8) begin : g_bad_width
        $error("router_pkt_reg: CRC-8 accumulator requires DATA_W == 8");
    end
`endif

    function automatic logic [DATA_W-1:0] acc_upd(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
`ifdef ROUTER_PKT_REG_CRC8_EN
        logic [DATA_W-1:0] c;
        c = a ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[DATA_W-1] ? ((c << 1) ^ DATA_W'(8'h07)) : (c << 1);
        end
        return c;
`else
        return a ^ b;
`endif
    endfunction

    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] pkt_check;
    logic              parity_q;
    logic [DATA_W-1:0] skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic sel_ld, sel_laf, sel_hold;
    logic skid_empty, skid_full;
    logic push, pop, drop, wr_en;
    logic err_set;

    always_comb begin
        sel_ld     = 1'b0;
        sel_laf    = 1'b0;
        sel_hold   = 1'b0;
        skid_empty = (skid_level == '0);
        skid_full  = (skid_level == LVL_W'(SKID_DEPTH));
        if (!detect_add && !lfd_state) begin
            sel_ld   = ld_state;
            sel_laf  = !ld_state && laf_state;
            sel_hold = !ld_state && !laf_state && full_state;
        end
        pop     = !sel_hold && !skid_empty && ((sel_ld && !fifo_full) || sel_laf);
        push    = sel_ld && (fifo_full || !skid_empty);
        drop    = push && skid_full && !pop;
        wr_en   = push && !drop;
        err_set = !detect_add && parity_done && !parity_q && (pkt_check != acc);
    end

    always_ff @(posedge router_clock) begin
        if (!resetn) begin
            hdr           <= '0;
            acc           <= '0;
            pkt_check     <= '0;
            parity_q      <= 1'b0;
            dout          <= '0;
            dout_valid    <= 1'b0;
            parity_done   <= 1'b0;
            low_pkt_valid <= 1'b0;
            err           <= 1'b0;
            err_count     <= '0;
            skid_level    <= '0;
            skid_overflow <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) skid_mem[i] <= '0;
        end else begin
            dout_valid <= 1'b0;
            parity_q   <= parity_done;

            if (detect_add) begin
                if (pkt_valid && data_in[1:0] != 2'b11) hdr <= data_in;
                acc         <= '0;
                pkt_check   <= '0;
                parity_done <= 1'b0;
            end else if (lfd_state) begin
                dout       <= hdr;
                dout_valid <= 1'b1;
                acc        <= acc_upd(acc, hdr);
            end else if (sel_ld) begin
                if (pop) begin
                    dout       <= skid_mem[rd_ptr];
                    dout_valid <= 1'b1;
                end else if (!push) begin
                    dout       <= data_in;
                    dout_valid <= 1'b1;
                end
                if (pkt_valid) begin
                    acc <= acc_upd(acc, data_in);
                end else begin
                    pkt_check   <= data_in;
                    parity_done <= 1'b1;
                end
            end else if (sel_laf && pop) begin
                dout       <= skid_mem[rd_ptr];
                dout_valid <= 1'b1;
            end

            // A new packet end outranks the FSM's clear request.
            if (sel_ld && !pkt_valid) low_pkt_valid <= 1'b1;
            else if (rst_int_reg)     low_pkt_valid <= 1'b0;

            if (wr_en) begin
                skid_mem[wr_ptr] <= data_in;
                wr_ptr <= (wr_ptr == PTR_W'(SKID_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == PTR_W'(SKID_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (wr_en && !pop)      skid_level <= skid_level + 1'b1;
            else if (pop && !wr_en) skid_level <= skid_level - 1'b1;
            if (drop) skid_overflow <= 1'b1;

            // Evaluated once, on the cycle after the check byte lands.
            if (detect_add) begin
                err <= 1'b0;
            end else if (parity_done && !parity_q) begin
                err <= err_set;
                if (err_set && !err && err_count != {ERR_CNT_W{1'b1}})
                    err_count <= err_count + 1'b1;
            end
        end
    end

endmodule
